// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder built around one CLA4 slice.
// Each RUN cycle adds one nibble of the operands. The ripple carry is held in a
// register between nibbles. Valid/ready handshakes are used on both sides.
// WIDTH must be a multiple of 4 and at least 8.

// cla4: one 4-bit carry-lookahead slice.
// Outputs are the sum, the carry-out, the group propagate and the group generate.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Bit propagate/generate terms and flattened lookahead carries.
    // Every carry is a two-level function of p, g and ci, with no ripple.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             pg_all
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic             pg_acc;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       cla_s;
    logic             cla_co;
    logic             cla_pg;
    logic             cla_gg_unused;

    logic             accept;
    logic             run_step;
    logic             run_last;

    // The single lookahead slice works on the nibble selected by idx.
    cla4 u_cla4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_reg),
        .s  (cla_s),
        .co (cla_co),
        .pg (cla_pg),
        .gg (cla_gg_unused)
    );

    // Select the current operand nibbles from the captured operands.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx == IDX_W'(n)) begin
                nib_a = a_reg[n*4 +: 4];
                nib_b = b_reg[n*4 +: 4];
            end
        end
    end

    // Handshake decode and the next-state logic for the sequencer.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        run_step   = 1'b0;
        run_last   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (idx == IDX_LAST) begin
                    run_last   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. An asynchronous reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the operands on accept. They stay fixed until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // Nibble index. It stops at the last nibble and is reset by the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (run_step && !run_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Ripple the carry between nibbles and fold the slice propagate into pg_acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
            pg_acc    <= 1'b1;
        end else if (accept) begin
            carry_reg <= ci;
            pg_acc    <= 1'b1;
        end else if (run_step) begin
            carry_reg <= cla_co;
            pg_acc    <= pg_acc & cla_pg;
        end
    end

    // Write each slice sum into its own nibble of the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (run_step) begin
            for (int n = 0; n < NIB; n++) begin
                if (idx == IDX_W'(n)) begin
                    sum[n*4 +: 4] <= cla_s;
                end
            end
        end
    end

    // Finalise the flags on the last nibble so they hold steady through DONE.
    // The carry into the MSB is a^b^s at that bit, so ovf is that value XOR co.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co     <= 1'b0;
            ovf    <= 1'b0;
            pg_all <= 1'b0;
        end else if (accept) begin
            co     <= 1'b0;
            ovf    <= 1'b0;
            pg_all <= 1'b0;
        end else if (run_last) begin
            co     <= cla_co;
            ovf    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ cla_s[3] ^ cla_co;
            pg_all <= pg_acc & cla_pg;
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds one 4-bit nibble per clock through a single CLA4 slice, registering the ripple carry between nibbles. It sits directly upstream of the CLA4: it owns the operand and carry sequencing, drives CLA4 A/B/Ci, and consumes S/Co/PG. It trades latency for area where a full-width lookahead tree is not justified. Valid/ready handshakes on both the operand side and the result side.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 8; NIB = WIDTH/4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and carry-in presented.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- out_valid  output  1  result held valid; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  a + b + ci, modulo 2^WIDTH.
- co  output  1  unsigned carry-out of the MSB.
- ovf  output  1  signed overflow: carry into the MSB XOR co.
- pg_all  output  1  AND of CLA4 PG over all nibbles, i.e. every bit position propagates.

## Operation
- Internal CLA4 instance: A = a_reg nibble idx, B = b_reg nibble idx, Ci = carry_reg. S, Co and PG are consumed. GG is left unused.
- FSM states:
  - IDLE: in_ready = 1. When in_valid is high, capture a, b and ci into a_reg, b_reg and carry_reg. Set idx = 0 and pg_acc = 1, then go to RUN.
  - RUN: each cycle, write S into sum nibble idx, load Co into carry_reg, and set pg_acc &= PG.
    - If idx == NIB-1, go to DONE. Otherwise increment idx.
  - DONE: out_valid = 1. co = carry_reg. ovf = a_reg[MSB] ^ b_reg[MSB] ^ sum[MSB] ^ co. pg_all = pg_acc.
    - When out_ready is high, go to IDLE. Otherwise stay.
- sum, co, ovf and pg_all are registered. They change only in RUN and on capture, and are stable for the whole DONE state.
- in_valid outside IDLE is ignored; no queuing.
- In DONE with out_ready high: the block returns to IDLE but does not accept in the same cycle. The next accept is one cycle later at the earliest.
- The idx counter is ceil(log2(NIB)) bits. It is never advanced past NIB-1; no wrap-around is reachable.
- Reset, asynchronous, from any state:
  - State goes to IDLE.
  - idx, a_reg, b_reg, carry_reg, sum, co, ovf, pg_all, out_valid all go to 0; pg_acc goes to 1.
  - in_ready reads 1 once rst_n is deasserted.
  - Reset mid-RUN or mid-DONE discards the operation. No out_valid pulse follows.

## Timing
- Accept at rising edge k (in_valid && in_ready). RUN occupies edges k+1 .. k+NIB. out_valid is high after edge k+NIB: NIB cycles of latency, 4 for WIDTH=16.
- Minimum initiation interval is NIB+2 cycles (capture, NIB RUN cycles, one DONE cycle) with out_ready tied high.
- The CLA4 path is combinational within one cycle: register to CLA4 to register. The critical path is one 4-bit lookahead slice plus the pg_acc AND.
- All outputs are synchronous to clk except the reset assertion effect.

## Test plan
All vectors use WIDTH=16.
- Wrap-around: a=0xFFFF, b=0x0003, ci=1 → sum=0x0003, co=1, ovf=0, pg_all=0, out_valid exactly 4 cycles after accept.
- Signed overflow: a=0x7FFF, b=0x0001, ci=0 → sum=0x8000, co=0, ovf=1. a=0x3333, b=0x5555, ci=0 → sum=0x8888, co=0, ovf=1.
- Full propagate chain: a=0xFFFF, b=0x0000, ci=1 → sum=0x0000, co=1, ovf=0, pg_all=1. Then ci=0 → sum=0xFFFF, co=0, pg_all=1.
- Backpressure: out_ready held 0 for 5 cycles in DONE; toggle in_valid with new operands meanwhile.
  - sum/co/ovf/pg_all stay constant and in_ready stays 0.
  - New operands are accepted only after out_ready=1 plus one cycle.
- Reset mid-operation: assert rst_n=0 at RUN idx=2 of a=0x1234+0x4321 → all outputs 0 immediately and in_ready=1 after release. No out_valid ever appears for the aborted op. The next op 0x1234+0x4321 → sum=0x5555.
- Back-to-back: 3 operations with in_valid and out_ready tied high → accepts spaced exactly 6 cycles apart, each result correct.
